// File: rtl/instr_decode_if.sv
// Fetch-to-decode and decode-to-ALU handshake bundle for the instruction decoder.
interface instr_decode_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [4:0]  out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm;
   logic [31:0] out_imm_ext;
   logic [25:0] out_jaddr;
   logic [31:0] out_jtarget;
   logic [1:0]  out_type;
   logic        out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm, out_imm_ext, out_jaddr, out_jtarget, out_type, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm, out_imm_ext, out_jaddr, out_jtarget, out_type, out_illegal
   );
endinterface

// File: rtl/instr_decode.sv
// MIPS decode stage: field split, classification, immediate extension and jump target,
// buffered in a 2-entry skid FIFO so fetch never sees ALU backpressure combinationally.
module instr_decode #(
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   instr_decode_if.slave  bus,
   output logic [15:0]    illegal_count
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned JADDR_W = 26;
   localparam int unsigned DEPTH   = 2;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned ICNT_W  = 16;

   typedef enum logic [1:0] {
      TYPE_R   = 2'd0,
      TYPE_I   = 2'd1,
      TYPE_J   = 2'd2,
      TYPE_ILL = 2'd3
   } instr_type_e;

   typedef struct packed {
      logic [OP_W-1:0]      opcode;
      logic [REG_W-1:0]     rs;
      logic [REG_W-1:0]     rt;
      logic [REG_W-1:0]     rd;
      logic [REG_W-1:0]     shamt;
      logic [OP_W-1:0]      funct;
      logic [IMM_W-1:0]     imm;
      logic [WORD_SIZE-1:0] imm_ext;
      logic [JADDR_W-1:0]   jaddr;
      logic [WORD_SIZE-1:0] jtarget;
      instr_type_e          itype;
      logic                 illegal;
   } dec_t;

   dec_t                 dec;
   dec_t                 head;
   dec_t                 mem [DEPTH];
   logic [WORD_SIZE-1:0] pc_plus4;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 push;
   logic                 pop;

   // Combinational decode of the word currently presented by fetch
   always_comb begin
      dec         = '0;
      pc_plus4    = bus.in_pc + WORD_SIZE'(4);
      dec.opcode  = bus.in_instr[31:26];
      dec.rs      = bus.in_instr[25:21];
      dec.rt      = bus.in_instr[20:16];
      dec.rd      = bus.in_instr[15:11];
      dec.shamt   = bus.in_instr[10:6];
      dec.funct   = bus.in_instr[5:0];
      dec.imm     = bus.in_instr[15:0];
      dec.jaddr   = bus.in_instr[25:0];
      dec.jtarget = {pc_plus4[31:28], bus.in_instr[25:0], 2'b00};

      unique case (dec.opcode)
         6'h00:                     dec.itype = TYPE_R;
         6'h02, 6'h03:              dec.itype = TYPE_J;
         6'h2C, 6'h2D, 6'h35, 6'h36,
         6'h37, 6'h3B, 6'h3C, 6'h3F: dec.itype = TYPE_ILL;
         default:                   dec.itype = TYPE_I;
      endcase
      dec.illegal = (dec.itype == TYPE_ILL);

      // Logical ops zero-extend, LUI shifts up, everything else sign-extends
      unique case (dec.opcode)
         6'h0C, 6'h0D, 6'h0E: dec.imm_ext = {16'h0000, dec.imm};
         6'h0F:               dec.imm_ext = {dec.imm, 16'h0000};
         default:             dec.imm_ext = {{16{dec.imm[15]}}, dec.imm};
      endcase
   end

   // in_ready depends only on registered occupancy, never on out_ready
   assign bus.in_ready  = (count != CNT_W'(DEPTH)) & ~rst;
   assign bus.out_valid = (count != '0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;
   assign head          = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating count of illegal words handed to the ALU; survives flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_count <= '0;
      end else if (pop && !flush && head.illegal && (illegal_count != {ICNT_W{1'b1}})) begin
         illegal_count <= illegal_count + ICNT_W'(1);
      end
   end

   assign bus.out_opcode  = head.opcode;
   assign bus.out_rs      = head.rs;
   assign bus.out_rt      = head.rt;
   assign bus.out_rd      = head.rd;
   assign bus.out_shamt   = head.shamt;
   assign bus.out_funct   = head.funct;
   assign bus.out_imm     = head.imm;
   assign bus.out_imm_ext = head.imm_ext;
   assign bus.out_jaddr   = head.jaddr;
   assign bus.out_jtarget = head.jtarget;
   assign bus.out_type    = head.itype;
   assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Randomized check of instr_decode against a queue-based reference model,
// plus directed cases with hand-computed values.
module tb_instr_decode;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [15:0] illegal_count;

   instr_decode_if bus ();

   instr_decode #(.WORD_SIZE(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .bus           (bus),
      .illegal_count (illegal_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of accepted (instr, pc) pairs
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   int unsigned m_ill;

   function automatic logic [1:0] exp_type(input logic [31:0] instr);
      logic [5:0] op;
      op = instr[31:26];
      if (op == 6'h00) return 2'd0;
      if (op == 6'h02 || op == 6'h03) return 2'd2;
      if (op inside {6'h2C, 6'h2D, 6'h35, 6'h36, 6'h37, 6'h3B, 6'h3C, 6'h3F}) return 2'd3;
      return 2'd1;
   endfunction

   function automatic logic [31:0] exp_imm_ext(input logic [31:0] instr);
      logic [31:0] imm;
      imm = instr & 32'h0000FFFF;
      case (instr[31:26])
         6'h0C, 6'h0D, 6'h0E: return imm;
         6'h0F:               return imm << 16;
         default:             return imm[15] ? (imm | 32'hFFFF0000) : imm;
      endcase
   endfunction

   function automatic logic [31:0] exp_jtarget(input logic [31:0] instr, input logic [31:0] pc);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      return (p4 & 32'hF0000000) | ((instr & 32'h03FFFFFF) << 2);
   endfunction

   always @(posedge clk or posedge rst) begin
      bit do_pop, do_push;
      ent_t e;
      if (rst) begin
         q.delete();
         m_ill = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         do_pop  = (q.size() > 0) && bus.out_ready;
         do_push = bus.in_valid && (q.size() < 2);
         if (do_pop) begin
            if (exp_type(q[0].instr) == 2'd3 && m_ill < 65535) m_ill++;
            void'(q.pop_front());
         end
         if (do_push) begin
            e.instr = bus.in_instr;
            e.pc    = bus.in_pc;
            q.push_back(e);
         end
      end
   end

   // Compare DUT against model every cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_ill_cnt",   32'(illegal_count), 32'd0);
      end else begin
         chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         chk("ill_cnt",   32'(illegal_count), m_ill);
         if (q.size() > 0) begin
            chk("opcode",  32'(bus.out_opcode), q[0].instr >> 26);
            chk("rs",      32'(bus.out_rs),     (q[0].instr >> 21) & 32'h1F);
            chk("rt",      32'(bus.out_rt),     (q[0].instr >> 16) & 32'h1F);
            chk("rd",      32'(bus.out_rd),     (q[0].instr >> 11) & 32'h1F);
            chk("shamt",   32'(bus.out_shamt),  (q[0].instr >> 6) & 32'h1F);
            chk("funct",   32'(bus.out_funct),  q[0].instr & 32'h3F);
            chk("imm",     32'(bus.out_imm),    q[0].instr & 32'hFFFF);
            chk("imm_ext", bus.out_imm_ext,     exp_imm_ext(q[0].instr));
            chk("jaddr",   32'(bus.out_jaddr),  q[0].instr & 32'h03FFFFFF);
            chk("jtarget", bus.out_jtarget,     exp_jtarget(q[0].instr, q[0].pc));
            chk("type",    32'(bus.out_type),   32'(exp_type(q[0].instr)));
            chk("illegal", 32'(bus.out_illegal), 32'(exp_type(q[0].instr) == 2'd3));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic drop_one();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   logic [5:0] ops [17] = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23,
                            6'h2C, 6'h2D, 6'h35, 6'h36, 6'h37, 6'h3B, 6'h3C, 6'h3F};

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready),  32'd1);
      chk("post_rst_opcode",   32'(bus.out_opcode), 32'd0);
      chk("post_rst_imm_ext",  bus.out_imm_ext,     32'd0);
      chk("post_rst_jtarget",  bus.out_jtarget,     32'd0);
      chk("post_rst_type",     32'(bus.out_type),   32'd0);
      step();

      // R-type field split
      send_one(32'h00221820, 32'h00000100);
      chk("r_valid", 32'(bus.out_valid), 32'd1);
      chk("r_type",  32'(bus.out_type),  32'd0);
      chk("r_rs",    32'(bus.out_rs),    32'd1);
      chk("r_rt",    32'(bus.out_rt),    32'd2);
      chk("r_rd",    32'(bus.out_rd),    32'd3);
      chk("r_shamt", 32'(bus.out_shamt), 32'd0);
      chk("r_funct", 32'(bus.out_funct), 32'h20);
      drop_one();

      // Immediate extension
      send_one(32'h2008FFFF, 32'h0);
      chk("addi_ext", bus.out_imm_ext, 32'hFFFFFFFF);
      drop_one();
      send_one(32'h34098000, 32'h0);
      chk("ori_ext", bus.out_imm_ext, 32'h00008000);
      drop_one();
      send_one(32'h3C011234, 32'h0);
      chk("lui_ext", bus.out_imm_ext, 32'h12340000);
      drop_one();

      // Jump target, including pc+4 wrap
      send_one(32'h08000010, 32'h40000000);
      chk("j_type",    32'(bus.out_type), 32'd2);
      chk("j_target",  bus.out_jtarget,   32'h40000040);
      drop_one();
      send_one(32'h08000010, 32'hFFFFFFFC);
      chk("j_wrap_target", bus.out_jtarget, 32'h00000040);
      drop_one();

      // Backpressure: third word waits until a slot frees
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h20010001;
      step();
      bus.in_instr = 32'h20020002;
      step();
      bus.in_instr = 32'h20030003;
      chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("bp_still_full", 32'(bus.in_ready), 32'd0);
      chk("bp_head_a",     32'(bus.out_imm),  32'h0001);
      bus.out_ready = 1'b1;
      step();
      chk("bp_ready_rise", 32'(bus.in_ready), 32'd1);
      chk("bp_head_b",     32'(bus.out_imm),  32'h0002);
      step();
      bus.in_valid = 1'b0;
      chk("bp_head_c", 32'(bus.out_imm),   32'h0003);
      chk("bp_c_vld",  32'(bus.out_valid), 32'd1);
      step();
      bus.out_ready = 1'b0;
      chk("bp_empty", 32'(bus.out_valid), 32'd0);

      // Illegal opcode
      send_one(32'hFC000000, 32'h0);
      chk("ill_flag", 32'(bus.out_illegal), 32'd1);
      chk("ill_type", 32'(bus.out_type),    32'd3);
      drop_one();
      chk("ill_count", 32'(illegal_count), 32'd1);

      // Flush with a concurrent input word
      send_one(32'h20040011, 32'h0);
      send_one(32'h20050022, 32'h0);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h2004BEEF;
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_empty", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      step();
      step();
      chk("flush_no_ghost", 32'(bus.out_valid), 32'd0);
      chk("flush_keeps_cnt", 32'(illegal_count), 32'd1);
      bus.out_ready = 1'b0;

      // Async reset with two entries buffered, no clock edge in between
      send_one(32'h20060033, 32'h0);
      send_one(32'h20070044, 32'h0);
      chk("pre_arst_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid",    32'(bus.out_valid), 32'd0);
      chk("arst_ill_cnt",  32'(illegal_count), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready),  32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("arst_release_ready", 32'(bus.in_ready), 32'd1);
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         flush         = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 1) == 0)
            bus.in_instr = {ops[$urandom_range(0, 16)], 26'($urandom)};
         else
            bus.in_instr = $urandom;
         bus.in_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
         step();
      end

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      step();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage feeding the ALU. Accepts 32-bit MIPS instruction words and their PC from fetch over a valid/ready handshake, then splits each word into R-type, I-type and J-type fields. It also classifies the instruction, extends the immediate and computes the jump target. Results are buffered in a 2-entry skid FIFO and presented to the ALU stage over a second valid/ready handshake, so fetch is never combinationally coupled to ALU backpressure.

## Interface
- WORD_SIZE, 32, instruction/PC width; only 32 supported
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  fetch presents a word
- in_ready  out  1  decode can accept
- in_instr  in  32  instruction word
- in_pc  in  32  address of in_instr
- out_valid  out  1  decoded entry available
- out_ready  in  1  ALU stage accepts
- out_opcode  out  6  instr[31:26]
- out_rs, out_rt, out_rd, out_shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- out_funct  out  6  instr[5:0]
- out_imm  out  16  instr[15:0]
- out_imm_ext  out  32  extended immediate
- out_jaddr  out  26  instr[25:0]
- out_jtarget  out  32  {pc_plus4[31:28], jaddr, 2'b00}
- out_type  out  2  0=R, 1=I, 2=J, 3=illegal
- out_illegal  out  1  out_type==3
- illegal_count  out  16  saturating count of illegal entries delivered

## Operation
- Decoding is combinational on in_instr/in_pc. The decoded record is written into the FIFO on input transfer (in_valid & in_ready).
- Classification:
  - opcode 0x00 → R.
  - 0x02 (J) and 0x03 (JAL) → J.
  - 0x2C, 0x2D, 0x35, 0x36, 0x37, 0x3B, 0x3C, 0x3F → illegal.
  - All others → I.
- Immediate extension:
  - ANDI (0x0C), ORI (0x0D), XORI (0x0E) → zero-extend.
  - LUI (0x0F) → {imm, 16'h0}.
  - All others → sign-extend.
  - R/J types still carry the sign-extended value; the ALU ignores it.
- pc_plus4 = in_pc + 4, mod 2^32 (wraps at 0xFFFFFFFC).
- FIFO: depth 2, wr/rd pointers of 1 bit, count 0..2.
  - in_ready = (count != 2) & ~rst, taken from registered count only. There is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0). Output fields always show the head entry.
  - Output transfer (out_valid & out_ready) pops the head.
- Simultaneous push and pop:
  - count unchanged; the head advances and the new entry lands at the tail.
  - At count==1 the new entry becomes visible the next cycle.
- Full (count==2): in_ready=0. A pop in that cycle frees a slot, and in_ready rises the following cycle.
- flush has priority over push and pop in the same cycle:
  - count and pointers go to 0.
  - A concurrent input transfer is dropped.
  - Any pop in that cycle does not count toward illegal_count.
- illegal_count increments on each output transfer with out_illegal=1. It saturates at 0xFFFF and is not cleared by flush.
- Output field values while out_valid=0 are don't-care for the consumer. They must not be X after reset.

## Timing
- Reset (async assert, sync deassert by upstream):
  - count=0, pointers=0, out_valid=0, in_ready=0 during reset.
  - in_ready=1 on the first cycle after release.
  - All FIFO storage, and therefore all out_* fields, reset to 0.
  - illegal_count=0.
- Latency: a word accepted at edge N has out_valid=1 from edge N through edge N+1, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained when out_ready stays high.
- out_* fields stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream: buffered entries are lost immediately and out_valid drops asynchronously.

## Test plan
- R-type: in_instr=0x00221820 → out_type=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20; out_valid one cycle after acceptance.
- Immediates:
  - 0x2008FFFF (ADDI) → out_imm_ext=0xFFFFFFFF.
  - 0x34098000 (ORI) → out_imm_ext=0x00008000.
  - 0x3C011234 (LUI) → out_imm_ext=0x12340000.
- Jump target:
  - 0x08000010 with pc=0x40000000 → out_type=2, out_jtarget=0x40000040.
  - Same word with pc=0xFFFFFFFC → out_jtarget=0x00000040 (pc+4 wraps to 0).
- Backpressure: out_ready=0, 3 back-to-back words → first two accepted, in_ready=0 on the third. Raise out_ready → entries drain in order, the third is accepted one cycle after the first pop, and no word is lost or duplicated.
- Illegal opcode and flush:
  - 0xFC000000 → out_illegal=1, out_type=3; illegal_count=1 after pop.
  - Two entries buffered, then flush asserted with in_valid=1 → next cycle out_valid=0 and count=0, and the concurrently presented word never appears.
- Async reset mid-transfer with count=2 → out_valid=0 and illegal_count=0 without a clock edge; in_ready=1 on the first cycle after release.
